// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the weighted round-robin arbiter:
//   arb_state_e : arbiter FSM encoding (ST_IDLE = 0, ST_OWN = 1)
//   idx_w()     : width of an index into an n-entry vector (minimum 1 bit)
// -----------------------------------------------------------------------------
package arb_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,   // nobody holds the grant
      ST_OWN  = 1'b1    // exactly one channel holds the grant
   } arb_state_e;

   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
// Purely combinational rotating priority search: returns the first set bit of
// i_req when scanning i_start, i_start+1, ..., N-1, 0, ..., i_start-1.
// Ports:
//   i_req   [N-1:0]   candidate request vector
//   i_start [IW-1:0]  index that has highest priority
//   o_found           some bit of i_req is set
//   o_idx   [IW-1:0]  index of the winner (0 when o_found is low)
// -----------------------------------------------------------------------------
module rr_priority_pick
   import arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]          i_req,
   input  logic [idx_w(N)-1:0]   i_start,
   output logic                  o_found,
   output logic [idx_w(N)-1:0]   o_idx
);

   localparam int IW = idx_w(N);

   // Rotate so that bit k of w_rot is request (i_start + k) mod N; the
   // lowest set bit of w_rot is then the winner.
   logic [N-1:0] w_rot;
   logic [IW:0]  w_sum;

   assign w_rot = N'({i_req, i_req} >> i_start);

   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      w_sum   = '0;
      // Descending scan: the last hit written is the lowest offset.
      for (int k = N - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            o_found = 1'b1;
            w_sum   = {1'b0, i_start} + (IW + 1)'(k);
         end
      end
      if (o_found) begin
         if (w_sum >= (IW + 1)'(N))
            o_idx = IW'(w_sum - (IW + 1)'(N));
         else
            o_idx = IW'(w_sum);
      end
   end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// -----------------------------------------------------------------------------
// weighted_rr_arbiter
// Round-robin arbiter where each tenure lasts up to weight[k] transfers
// (weight 0 behaves as 1). The owner keeps the grant while it requests and
// still has credit; on release the pointer moves past the owner and the
// next requester is picked in the same cycle, so owners change back-to-back.
// Ports:
//   clk                     rising-edge clock
//   rst_n                   asynchronous active-low reset
//   req      [N-1:0]        level request per channel
//   weight   [N*CW-1:0]     channel i weight in [i*CW +: CW], sampled at entry
//   done                    one-cycle pulse: owner finished one transfer
//   grant    [N-1:0]        registered one-hot grant or zero
//   grant_valid             registered, high when grant is non-zero
//   grant_id [$clog2(N)-1:0] registered owner index, 0 when idle
// -----------------------------------------------------------------------------
module weighted_rr_arbiter
   import arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int CW = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N-1:0]          req,
   input  logic [N*CW-1:0]       weight,
   input  logic                  done,
   output logic [N-1:0]          grant,
   output logic                  grant_valid,
   output logic [$clog2(N)-1:0]  grant_id
);

   localparam int IW = idx_w(N);

   arb_state_e    r_state;
   logic [IW-1:0] r_ptr;
   logic [CW:0]   r_credit;
   logic [N-1:0]  r_grant;
   logic          r_gv;
   logic [IW-1:0] r_gid;

   logic [CW-1:0] w_wt [N];
   logic          w_release;
   logic [IW-1:0] w_next_ptr;
   logic [N-1:0]  w_pick_req;
   logic [IW-1:0] w_pick_start;
   logic          w_pick_found;
   logic [IW-1:0] w_pick_idx;
   logic [N-1:0]  w_pick_onehot;
   logic [CW-1:0] w_pick_wt;
   logic [CW:0]   w_load_credit;

   for (genvar g = 0; g < N; g++) begin : g_wt
      assign w_wt[g] = weight[g*CW +: CW];
   end

   // r_gid is the owner index while in ST_OWN.
   assign w_release  = (r_state == ST_OWN) &&
                       (!req[r_gid] || (done && (r_credit == (CW + 1)'(1))));
   assign w_next_ptr = (r_gid == IW'(N - 1)) ? '0 : r_gid + 1'b1;

   // One search serves both cases: fresh arbitration from ptr when idle,
   // and re-arbitration past the releasing owner (owner bit masked) in OWN.
   assign w_pick_req   = (r_state == ST_IDLE) ? req   : (req & ~r_grant);
   assign w_pick_start = (r_state == ST_IDLE) ? r_ptr : w_next_ptr;

   rr_priority_pick #(.N(N)) u_pick (
      .i_req   (w_pick_req),
      .i_start (w_pick_start),
      .o_found (w_pick_found),
      .o_idx   (w_pick_idx)
   );

   assign w_pick_onehot = N'(1) << w_pick_idx;
   assign w_pick_wt     = w_wt[w_pick_idx];
   assign w_load_credit = (w_pick_wt == '0) ? (CW + 1)'(1) : {1'b0, w_pick_wt};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_ptr    <= '0;
         r_credit <= '0;
         r_grant  <= '0;
         r_gv     <= 1'b0;
         r_gid    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // done is meaningless without an owner and is ignored here.
               if (w_pick_found) begin
                  r_state  <= ST_OWN;
                  r_grant  <= w_pick_onehot;
                  r_gv     <= 1'b1;
                  r_gid    <= w_pick_idx;
                  r_credit <= w_load_credit;
               end
            end
            ST_OWN: begin
               if (w_release) begin
                  r_ptr <= w_next_ptr;
                  if (w_pick_found) begin
                     r_grant  <= w_pick_onehot;
                     r_gid    <= w_pick_idx;
                     r_credit <= w_load_credit;
                  end else begin
                     // A lone re-requesting owner is picked up again via IDLE.
                     r_state  <= ST_IDLE;
                     r_grant  <= '0;
                     r_gv     <= 1'b0;
                     r_gid    <= '0;
                     r_credit <= '0;
                  end
               end else if (done) begin
                  // Not releasing with done set implies credit > 1.
                  r_credit <= r_credit - (CW + 1)'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign grant       = r_grant;
   assign grant_valid = r_gv;
   assign grant_id    = r_gid;

endmodule
